hilo_muldiv: RTL and testbench

- Parametrised HI/LO unit for the EX stage of the MIPS core.
- Combines the HI/LO architectural registers with their write paths:
  - MTHI/MTLO moves.
  - A pipelined signed/unsigned multiplier.
  - A radix-2 iterative signed/unsigned divider.
- Exposes busy/done handshakes so the hazard unit can stall on MFHI/MFLO or on a new mul/div.

---
 rtl/hilo_pkg.sv | 17 +
 rtl/hilo_muldiv_if.sv | 25 ++
 rtl/hilo_div_core.sv | 49 ++++
 rtl/hilo_muldiv.sv | 122 ++++++++++++
 tb/tb_hilo_muldiv.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: op encoding, FSM states and helpers shared by the HI/LO unit.
package hilo_pkg;
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MTHI  = 3'b001;
    localparam logic [2:0] OP_MTLO  = 3'b010;
    localparam logic [2:0] OP_MTHL  = 3'b011;
    localparam logic [2:0] OP_MULT  = 3'b100;
    localparam logic [2:0] OP_MULTU = 3'b101;
    localparam logic [2:0] OP_DIV   = 3'b110;
    localparam logic [2:0] OP_DIVU  = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX} state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return op[2];
    endfunction
endpackage

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: request/status bundle between the EX stage and the HI/LO unit.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             op_ready;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  op_ready, busy, done, div_by_zero, hi_out, lo_out
    );
    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output op_ready, busy, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_div_core.sv
// hilo_div_core: unsigned restoring divider, one quotient bit per clock.
module hilo_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] q_q, r_q, d_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH:0]   trial;

    // Shift the next dividend bit into the partial remainder and try the subtract.
    assign trial = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
    assign last = run_q && cnt_q == CW'(WIDTH - 1);
    assign quotient = q_q;
    assign remainder = r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
            r_q <= '0;
            d_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            q_q <= dividend;
            r_q <= '0;
            d_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (flush) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            q_q <= {q_q[WIDTH-2:0], !trial[WIDTH]};
            r_q <= trial[WIDTH] ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : trial[WIDTH-1:0];
            cnt_q <= cnt_q + 1'b1;
            run_q <= !last;
        end
    end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO registers with move, pipelined multiply and iterative divide paths.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MUL_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    hilo_muldiv_if.slave bus
);
    localparam int MCW = MUL_STAGES > 1 ? $clog2(MUL_STAGES) : 1;
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_abs, b_abs, quot, rem;
    logic [2*WIDTH-1:0] prod_q, prod_d, mul_a, mul_b;
    logic [MCW-1:0]     mcnt_q, mcnt_d;
    logic               done_q, done_d, dbz_q, dbz_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic               accept, sgn, a_neg, b_neg, b_zero, div_start, div_last, mul_last;

    assign bus.op_ready = state_q == IDLE && !bus.flush;
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign accept = bus.op_valid && bus.op_ready;
    assign sgn = !bus.op[0];
    assign a_neg = sgn && bus.src_a[WIDTH-1];
    assign b_neg = sgn && bus.src_b[WIDTH-1];
    assign b_zero = bus.src_b == '0;
    assign div_start = accept && bus.op[2:1] == 2'b11 && !b_zero;
    // Sign-extending to 2*WIDTH lets one unsigned multiply serve MULT and MULTU.
    assign mul_a = {{WIDTH{a_neg}}, bus.src_a};
    assign mul_b = {{WIDTH{b_neg}}, bus.src_b};
    assign a_abs = a_neg ? -bus.src_a : bus.src_a;
    assign b_abs = b_neg ? -bus.src_b : bus.src_b;
    assign mul_last = mcnt_q == MCW'(MUL_STAGES - 1);

    hilo_div_core #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .flush    (bus.flush),
        .dividend (a_abs),
        .divisor  (b_abs),
        .quotient (quot),
        .remainder(rem),
        .last     (div_last)
    );

    always_comb begin
        state_d = state_q;
        hi_d = hi_q;
        lo_d = lo_q;
        prod_d = prod_q;
        mcnt_d = mcnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        done_d = 1'b0;
        dbz_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !is_muldiv(bus.op)) begin
                    hi_d = bus.op[0] ? bus.src_a : hi_q;
                    lo_d = bus.op[1] ? (bus.op[0] ? bus.src_b : bus.src_a) : lo_q;
                end else if (accept && !bus.op[1]) begin
                    state_d = MUL_WAIT;
                    prod_d = mul_a * mul_b;
                    mcnt_d = '0;
                end else if (accept) begin
                    state_d = b_zero ? IDLE : DIV_RUN;
                    done_d = b_zero;
                    dbz_d = b_zero;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                end
            end
            MUL_WAIT: begin
                state_d = bus.flush || mul_last ? IDLE : MUL_WAIT;
                mcnt_d = mcnt_q + 1'b1;
                if (!bus.flush && mul_last) begin
                    {hi_d, lo_d} = prod_q;
                    done_d = 1'b1;
                end
            end
            DIV_RUN: state_d = bus.flush ? IDLE : div_last ? DIV_FIX : DIV_RUN;
            DIV_FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    lo_d = qneg_q ? -quot : quot;
                    hi_d = rneg_q ? -rem : rem;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q <= '0;
            lo_q <= '0;
            prod_q <= '0;
            mcnt_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            prod_q <= prod_d;
            mcnt_q <= mcnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            done_q <= done_d;
            dbz_q <= dbz_d;
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed and random checks of the HI/LO unit against an arithmetic model.
module tb_hilo_muldiv;
    import hilo_pkg::*;
    localparam int W = 32;
    localparam int MS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(W)) bus ();
    hilo_muldiv #(.WIDTH(W), .MUL_STAGES(MS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] m_hi, m_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: HI/LO contents after an op, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic dz);
        longint sa, sb;
        logic [63:0] p;
        dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            OP_MTHL: begin m_hi = a; m_lo = b; end
            OP_MULT: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) dz = 1'b1;
                else if (op == OP_DIV) begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            default: ;
        endcase
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
        logic dz;
        int lat;
        model(op, a, b, dz);
        bus.op_valid = 1'b1;
        bus.op = op;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        if (op[2] && !dz) begin
            chk({tag, " op_ready"}, 64'(bus.op_ready), 0);
            lat = 0;
            while (bus.busy === 1'b1 && lat < 100) begin
                lat++;
                @(negedge clk);
            end
            chk({tag, " busy_cycles"}, 64'(lat), 64'(op[1] ? W + 1 : MS));
        end else chk({tag, " busy"}, 64'(bus.busy), 0);
        chk({tag, " done"}, 64'(bus.done), 64'(op[2]));
        chk({tag, " dbz"}, 64'(bus.div_by_zero), 64'(dz));
        chk({tag, " hilo"}, {bus.hi_out, bus.lo_out}, {m_hi, m_lo});
        if (op[2]) begin
            @(negedge clk);
            chk({tag, " pulse_end"}, {62'b0, bus.done, bus.div_by_zero}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic saw;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        bus.op_valid = 1'b0;
        bus.op = OP_NOP;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        chk("reset hilo", {bus.hi_out, bus.lo_out}, 0);
        chk("reset busy/done", {61'b0, bus.busy, bus.done, bus.div_by_zero}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset op_ready", 64'(bus.op_ready), 1);

        // Asynchronous reset in the middle of a multiply.
        run(OP_MTHL, 32'h5, 32'h6, "pre_rst");
        bus.op_valid = 1'b1;
        bus.op = OP_MULT;
        bus.src_a = 32'h7;
        bus.src_b = 32'h9;
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("rst mul busy", 64'(bus.busy), 1);
        #2 rst = 1'b1;
        #1 chk("async rst hilo", {bus.hi_out, bus.lo_out}, 0);
        chk("async rst busy", 64'(bus.busy), 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (5) begin @(negedge clk); saw |= bus.done; end
        chk("rst no done", 64'(saw), 0);

        run(OP_MTHI, 32'hDEADBEEF, 32'h0, "mthi");
        run(OP_MTLO, 32'h12345678, 32'h0, "mtlo");
        run(OP_MTHL, 32'h1, 32'h2, "mthl");
        run(OP_MULT, 32'hFFFFFFFE, 32'h3, "mult");
        chk("mult const", {bus.hi_out, bus.lo_out}, 64'hFFFFFFFF_FFFFFFFA);
        run(OP_MULTU, 32'hFFFFFFFE, 32'h3, "multu");
        chk("multu const", {bus.hi_out, bus.lo_out}, 64'h00000002_FFFFFFFA);
        run(OP_DIV, 32'hFFFFFFF9, 32'h2, "div");
        chk("div const", {bus.hi_out, bus.lo_out}, 64'hFFFFFFFF_FFFFFFFD);
        run(OP_DIVU, 32'd100, 32'd7, "divu");
        chk("divu const", {bus.hi_out, bus.lo_out}, {32'd2, 32'd14});
        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min");
        chk("div_min const", {bus.hi_out, bus.lo_out}, 64'h00000000_80000000);
        run(OP_MTHL, 32'h1, 32'h2, "pre_dz");
        run(OP_DIV, 32'h5, 32'h0, "div_zero");

        // Flush ten cycles into a divide.
        bus.op_valid = 1'b1;
        bus.op = OP_DIVU;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        #1 chk("flush op_ready", 64'(bus.op_ready), 0);
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush div busy", 64'(bus.busy), 0);
        chk("flush div hilo", {bus.hi_out, bus.lo_out}, {m_hi, m_lo});
        run(OP_MTLO, 32'h55, 32'h0, "mtlo_after_flush");
        saw = 1'b0;
        repeat (30) begin @(negedge clk); saw |= bus.done; end
        chk("flush div no done", 64'(saw), 0);

        // Flush landing on the multiply writeback edge.
        bus.op_valid = 1'b1;
        bus.op = OP_MULTU;
        bus.src_a = 32'h1234;
        bus.src_b = 32'h5678;
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush mul busy/done", {62'b0, bus.busy, bus.done}, 0);
        chk("flush mul hilo", {bus.hi_out, bus.lo_out}, {m_hi, m_lo});

        // An op offered while idle with flush high is dropped.
        bus.op_valid = 1'b1;
        bus.op = OP_MTHI;
        bus.src_a = 32'hBAD;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.flush = 1'b0;
        chk("idle flush drop", {bus.hi_out, bus.lo_out}, {m_hi, m_lo});

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 13 == 5) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            run(rop, ra, rb, $sformatf("rnd%0d op%0d", i, rop));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
